// File: rtl/yarp_pkg.sv
// Shared YARP core types: data access sizes, LSU states and the
// alignment legality check used at request time.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b11
  } data_access_size;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  // Size 2'b10 has no encoding and is rejected like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/yarp_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and data replication,
// and load-data extraction with sign/zero extension.
module yarp_lsu_align
  import yarp_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_zero_ext,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be        = '0;
    st_wdata_rep = st_wdata;
    case (st_size)
      BYTE: begin
        st_be        = 4'b0001 << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      HALF: begin
        st_be        = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      WORD:    st_be = 4'b1111;
      default: st_be = '0;
    endcase
  end

  always_comb begin
    shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    case (ld_size)
      BYTE:    ld_data = {{24{~ld_zero_ext & shifted[7]}}, shifted[7:0]};
      HALF:    ld_data = {{16{~ld_zero_ext & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/yarp_lsu.sv
// YARP load/store unit: one outstanding access on a req/gnt/rvalid bus,
// with misalignment rejection and a per-phase timeout.
module yarp_lsu
  import yarp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_req_i,
  input  logic        ex_wr_i,
  input  logic [1:0]  ex_byte_i,
  input  logic        ex_zero_extnd_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rdata_vld_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_t  state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        timeout;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        ext_q;
  logic        misalign;
  logic        accept;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;

  yarp_lsu_align u_align (
    .st_size      (ex_byte_i),
    .st_addr_lo   (ex_addr_i[1:0]),
    .st_wdata     (ex_wdata_i),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (size_q),
    .ld_addr_lo   (addr_lo_q),
    .ld_zero_ext  (ext_q),
    .ld_rdata     (mem_rdata_i),
    .ld_data      (ld_data)
  );

  assign misalign    = is_misaligned(ex_byte_i, ex_addr_i[1:0]);
  assign accept      = !reset && (state == IDLE) && ex_req_i && !misalign;
  assign lsu_stall_o = accept || (state == REQ) || (state == WAIT);

  // cnt holds cycles already spent in the phase; abort on the cycle that completes the budget.
  assign cnt_inc = cnt + 8'd1;
  assign timeout = (cnt_inc == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_lo_q       <= '0;
      size_q          <= '0;
      ext_q           <= 1'b0;
      mem_req_o       <= 1'b0;
      mem_wr_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_be_o        <= '0;
      mem_wdata_o     <= '0;
      lsu_rdata_o     <= '0;
      lsu_rdata_vld_o <= 1'b0;
      lsu_misalign_o  <= 1'b0;
      lsu_err_o       <= 1'b0;
    end else begin
      lsu_rdata_vld_o <= 1'b0;
      lsu_misalign_o  <= 1'b0;
      lsu_err_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_req_i && misalign) begin
            lsu_misalign_o <= 1'b1;
          end else if (accept) begin
            state       <= REQ;
            cnt         <= '0;
            mem_req_o   <= 1'b1;
            mem_wr_o    <= ex_wr_i;
            mem_addr_o  <= {ex_addr_i[31:2], 2'b00};
            mem_be_o    <= st_be;
            mem_wdata_o <= st_wdata_rep;
            addr_lo_q   <= ex_addr_i[1:0];
            size_q      <= ex_byte_i;
            ext_q       <= ex_zero_extnd_i;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            cnt       <= '0;
            if (mem_wr_o) begin
              state <= DONE;
            end else if (mem_rvalid_i) begin
              lsu_rdata_o     <= ld_data;
              lsu_rdata_vld_o <= 1'b1;
              state           <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (timeout) begin
            mem_req_o <= 1'b0;
            lsu_err_o <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            lsu_rdata_o     <= ld_data;
            lsu_rdata_vld_o <= 1'b1;
            state           <= DONE;
          end else if (timeout) begin
            lsu_err_o <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yarp_lsu.sv
// Directed self-checking bench for yarp_lsu (timeout budget shortened to 4).
module tb_yarp_lsu;
  import yarp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_req_i, ex_wr_i, ex_zero_extnd_i;
  logic [1:0]  ex_byte_i;
  logic [31:0] ex_addr_i, ex_wdata_i;
  logic        lsu_stall_o, lsu_rdata_vld_o, lsu_misalign_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  yarp_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_req_i        (ex_req_i),
    .ex_wr_i         (ex_wr_i),
    .ex_byte_i       (ex_byte_i),
    .ex_zero_extnd_i (ex_zero_extnd_i),
    .ex_addr_i       (ex_addr_i),
    .ex_wdata_i      (ex_wdata_i),
    .lsu_stall_o     (lsu_stall_o),
    .lsu_rdata_o     (lsu_rdata_o),
    .lsu_rdata_vld_o (lsu_rdata_vld_o),
    .lsu_misalign_o  (lsu_misalign_o),
    .lsu_err_o       (lsu_err_o),
    .mem_req_o       (mem_req_o),
    .mem_wr_o        (mem_wr_o),
    .mem_addr_o      (mem_addr_o),
    .mem_be_o        (mem_be_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic zx,
                       input logic [31:0] addr, input logic [31:0] wd);
    ex_req_i = 1'b1; ex_wr_i = wr; ex_byte_i = sz; ex_zero_extnd_i = zx;
    ex_addr_i = addr; ex_wdata_i = wd;
  endtask

  initial begin
    reset = 1'b1;
    ex_req_i = 1'b0; ex_wr_i = 1'b0; ex_byte_i = 2'b00; ex_zero_extnd_i = 1'b0;
    ex_addr_i = '0; ex_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    tick(); tick();
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_stall", 32'(lsu_stall_o), 0);
    chk("rst_be", 32'(mem_be_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_rdata", lsu_rdata_o, 0);
    chk("rst_flags", {29'd0, lsu_rdata_vld_o, lsu_misalign_o, lsu_err_o}, 0);
    reset = 1'b0;
    tick();

    // LB 0x1003 sign-extended
    issue(1'b0, BYTE, 1'b0, 32'h0000_1003, 32'h0);
    #1 chk("lb_stall_accept", 32'(lsu_stall_o), 1);
    tick();
    ex_req_i = 1'b0;
    chk("lb_req", 32'(mem_req_o), 1);
    chk("lb_addr", mem_addr_o, 32'h0000_1000);
    chk("lb_be", 32'(mem_be_o), 32'h8);
    chk("lb_wr", 32'(mem_wr_o), 0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("lb_wait_req", 32'(mem_req_o), 0);
    chk("lb_wait_stall", 32'(lsu_stall_o), 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_FF7F;
    tick();
    mem_rvalid_i = 1'b0;
    chk("lb_vld", 32'(lsu_rdata_vld_o), 1);
    chk("lb_rdata", lsu_rdata_o, 32'hFFFF_FF80);
    chk("lb_done_stall", 32'(lsu_stall_o), 0);
    tick();
    chk("lb_vld_drop", 32'(lsu_rdata_vld_o), 0);
    chk("lb_rdata_hold", lsu_rdata_o, 32'hFFFF_FF80);

    // SH 0x2002 with grant on third request cycle
    issue(1'b1, HALF, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
    tick();
    ex_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", 32'(mem_req_o), 1);
      chk("sh_addr", mem_addr_o, 32'h0000_2000);
      chk("sh_be", 32'(mem_be_o), 32'hC);
      chk("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
      chk("sh_wr", 32'(mem_wr_o), 1);
      chk("sh_stall", 32'(lsu_stall_o), 1);
      if (i == 2) mem_gnt_i = 1'b1;
      tick();
    end
    mem_gnt_i = 1'b0;
    chk("sh_done_req", 32'(mem_req_o), 0);
    chk("sh_done_stall", 32'(lsu_stall_o), 0);
    chk("sh_no_vld", 32'(lsu_rdata_vld_o), 0);
    tick();

    // LW 0x3001 misaligned
    issue(1'b0, WORD, 1'b0, 32'h0000_3001, 32'h0);
    #1 chk("lw_mis_stall0", 32'(lsu_stall_o), 0);
    tick();
    ex_req_i = 1'b0;
    chk("lw_mis_pulse", 32'(lsu_misalign_o), 1);
    chk("lw_mis_req", 32'(mem_req_o), 0);
    chk("lw_mis_stall", 32'(lsu_stall_o), 0);
    tick();
    chk("lw_mis_drop", 32'(lsu_misalign_o), 0);
    chk("lw_mis_req2", 32'(mem_req_o), 0);

    // Illegal size 2'b10 rejected
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
    tick();
    ex_req_i = 1'b0;
    chk("size10_mis", 32'(lsu_misalign_o), 1);
    chk("size10_req", 32'(mem_req_o), 0);
    tick();

    // LHU 0x0, grant and rvalid together
    issue(1'b0, HALF, 1'b1, 32'h0000_0000, 32'h0);
    tick();
    ex_req_i = 1'b0;
    chk("lhu_be", 32'(mem_be_o), 32'h3);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_8001;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    chk("lhu_vld", 32'(lsu_rdata_vld_o), 1);
    chk("lhu_rdata", lsu_rdata_o, 32'h0000_8001);
    chk("lhu_no_wait", 32'(lsu_stall_o), 0);
    tick();

    // LH 0x2 sign-extended from upper half
    issue(1'b0, HALF, 1'b0, 32'h0000_0002, 32'h0);
    tick();
    ex_req_i = 1'b0;
    chk("lh_be", 32'(mem_be_o), 32'hC);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8001_1234;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    chk("lh_rdata", lsu_rdata_o, 32'hFFFF_8001);
    tick();

    // SB 0x5 byte lane 1
    issue(1'b1, BYTE, 1'b0, 32'h0000_0005, 32'hCAFE_BAEF);
    tick();
    ex_req_i = 1'b0;
    chk("sb_be", 32'(mem_be_o), 32'h2);
    chk("sb_wdata", mem_wdata_o, 32'hEFEF_EFEF);
    chk("sb_addr", mem_addr_o, 32'h0000_0004);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    tick();

    // LW timeout while waiting for rvalid
    issue(1'b0, WORD, 1'b0, 32'h0000_4000, 32'h0);
    tick();
    ex_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_stall", 32'(lsu_stall_o), 1);
      chk("to_wait_err", 32'(lsu_err_o), 0);
      tick();
    end
    chk("to_err", 32'(lsu_err_o), 1);
    chk("to_vld", 32'(lsu_rdata_vld_o), 0);
    chk("to_stall", 32'(lsu_stall_o), 0);
    tick();
    chk("to_err_drop", 32'(lsu_err_o), 0);
    chk("to_rdata_hold", lsu_rdata_o, 32'hFFFF_8001);

    // Timeout while never granted drops the request
    issue(1'b0, WORD, 1'b0, 32'h0000_4004, 32'h0);
    tick();
    ex_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tor_req", 32'(mem_req_o), 1);
      tick();
    end
    chk("tor_err", 32'(lsu_err_o), 1);
    chk("tor_req_drop", 32'(mem_req_o), 0);
    tick();

    // Reset in WAIT, late rvalid ignored
    issue(1'b0, WORD, 1'b0, 32'h0000_5000, 32'h0);
    tick();
    ex_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_stall", 32'(lsu_stall_o), 0);
    chk("rw_addr", mem_addr_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0;
    chk("rw_vld", 32'(lsu_rdata_vld_o), 0);
    chk("rw_rdata", lsu_rdata_o, 0);
    chk("rw_req", 32'(mem_req_o), 0);
    chk("rw_be", 32'(mem_be_o), 0);
    tick();
    chk("rw_vld2", 32'(lsu_rdata_vld_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yarp_lsu.md
YARP_LSU -- requirements
Module: yarp_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles spent in REQ or WAIT before abort; 8-bit counter.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-003 ex_req_i  in  1  memory op present (control data_req).
REQ-004 ex_wr_i  in  1  1=store, 0=load (control data_wr).
REQ-005 ex_byte_i  in  2  access size, data_access_size encoding (Byte/Half/Word).
REQ-006 ex_zero_extnd_i  in  1  1=zero-extend load (LBU/LHU), 0=sign-extend.
REQ-007 ex_addr_i  in  32  byte address (ALU result).
REQ-008 ex_wdata_i  in  32  store data (rs2).
REQ-009 lsu_stall_o  out  1  hold core pipeline.
REQ-010 lsu_rdata_o  out  32  extended load result.
REQ-011 lsu_rdata_vld_o  out  1  one-cycle load-complete strobe.
REQ-012 lsu_misalign_o  out  1  one-cycle misaligned/illegal-size strobe.
REQ-013 lsu_err_o  out  1  one-cycle timeout strobe.
REQ-014 mem_req_o, mem_wr_o  out  1 each; mem_addr_o  out  32 (addr[1:0]=0); mem_be_o  out  4; mem_wdata_o  out  32.
REQ-015 mem_gnt_i, mem_rvalid_i  in  1 each; mem_rdata_i  in  32.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, DONE.
REQ-017 Misaligned = Half with addr[0]=1, Word with addr[1:0]!=0, or size 2'b10; in IDLE such a request pulses lsu_misalign_o next cycle, no mem_req, no stall, state stays IDLE.
REQ-018 IDLE with aligned ex_req_i: register addr/wdata/size/ext/wr, go REQ; lsu_stall_o high combinationally that cycle.
REQ-019 lsu_stall_o SHALL be high in REQ and WAIT, low in DONE and IDLE-without-aligned-request.
REQ-020 REQ: mem_req_o=1; mem_addr_o, mem_be_o, mem_wdata_o, mem_wr_o stable until mem_gnt_i.
REQ-021 REQ+gnt: store -> DONE; load -> WAIT; load with gnt and rvalid same cycle -> DONE, capturing data.
REQ-022 WAIT+mem_rvalid_i: capture extended data into lsu_rdata_o, go DONE; rvalid outside WAIT/REQ ignored.
REQ-023 DONE: one cycle, lsu_rdata_vld_o=1 for loads only, then IDLE; a new request is accepted only in IDLE.
REQ-024 mem_be_o: Byte 4'b0001<<addr[1:0]; Half 4'b0011<<{addr[1],1'b0}; Word 4'b1111.
REQ-025 mem_wdata_o: Byte {4{wdata[7:0]}}; Half {2{wdata[15:0]}}; Word wdata.
REQ-026 Load: shift mem_rdata_i right by addr[1:0]*8, take low 8/16/32 bits, extend per ex_zero_extnd_i (ignored for Word).
REQ-027 Timeout counter clears on entering REQ and on gnt; in REQ/WAIT, count reaching TIMEOUT_CYCLES drops mem_req_o, pulses lsu_err_o, goes DONE with lsu_rdata_vld_o=0.
REQ-028 lsu_rdata_o holds last load value until next load completes.

Reset
REQ-029 On reset: state IDLE, counter 0, mem_req_o/mem_wr_o/lsu_stall_o/lsu_rdata_vld_o/lsu_misalign_o/lsu_err_o 0, mem_be_o 0, mem_addr_o/mem_wdata_o/lsu_rdata_o 0.
REQ-030 Reset mid-transaction SHALL abandon it; a response arriving after reset is ignored.

Structure
REQ-031 lsu_state_t enum (IDLE, REQ, WAIT, DONE) SHALL be added to yarp_pkg; data_access_size reused from yarp_pkg.
REQ-032 Byte-lane/extension logic SHALL be a combinational sub-module yarp_lsu_align (be, wdata replication, load extraction).

Verification
REQ-033 LB addr 0x1003, rdata 0x80FF_FF7F, ext=0 -> be 4'b1000, addr 0x1000, lsu_rdata_o 0xFFFF_FF80, vld one cycle.
REQ-034 SH addr 0x2002, wdata 0x1234_ABCD, gnt after 3 cycles -> req held 3 cycles stable, be 4'b1100, wdata 0xABCD_ABCD, stall high until DONE.
REQ-035 LW addr 0x3001 -> misalign pulse next cycle, mem_req_o never high, stall low.
REQ-036 LHU addr 0x0, gnt and rvalid same cycle, rdata 0x0000_8001 -> rdata_o 0x0000_8001, REQ->DONE, no WAIT.
REQ-037 TIMEOUT_CYCLES=4, load granted, no rvalid -> lsu_err_o pulse after 4 WAIT cycles, vld stays 0, IDLE after.
REQ-038 Reset asserted in WAIT, then rvalid -> IDLE, no vld, outputs at reset values.
